// File: rtl/insn_decoder_pkg.sv
// Shared instruction definitions for the fetch/decode boundary.
// Holds the instruction and address widths, the field layout (opcode at the top,
// then rd, then rs, then the immediate), and the decoded-field record.
// decode_insn() slices an instruction into that record.
package insn_decoder_pkg;

    localparam int LEN_INSN      = 32;
    localparam int MEM_INSN_ADDR = 10;
    localparam int LEN_OPCODE    = 6;
    localparam int LEN_REG       = 5;
    localparam int NUM_OPCODES   = 40;

    // Derived from the widths above; not meant to be overridden.
    localparam int LEN_IMM = LEN_INSN - LEN_OPCODE - 2 * LEN_REG;
    localparam int OPC_LSB = LEN_INSN - LEN_OPCODE;
    localparam int RD_LSB  = OPC_LSB - LEN_REG;
    localparam int RS_LSB  = RD_LSB - LEN_REG;

    // Named opcodes; any value >= NUM_OPCODES is illegal.
    typedef enum logic [LEN_OPCODE-1:0] {
        OP_NOP  = 6'd0,
        OP_ADD  = 6'd1,
        OP_SUB  = 6'd2,
        OP_ADDI = 6'd3,
        OP_LD   = 6'd8,
        OP_ST   = 6'd9,
        OP_BEQ  = 6'd16,
        OP_JMP  = 6'd24,
        OP_HALT = 6'd39
    } opcode_e;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

    typedef struct packed {
        logic [LEN_OPCODE-1:0] opcode;
        logic [LEN_REG-1:0]    rd;
        logic [LEN_REG-1:0]    rs;
        logic [LEN_IMM-1:0]    imm;
        logic                  illegal;
    } dec_fields_t;

    localparam int DEC_W = LEN_OPCODE + 2 * LEN_REG + LEN_IMM + 1;

    function automatic dec_fields_t decode_insn(input logic [LEN_INSN-1:0] insn);
        dec_fields_t d;
        d.opcode  = insn[OPC_LSB +: LEN_OPCODE];
        d.rd      = insn[RD_LSB +: LEN_REG];
        d.rs      = insn[RS_LSB +: LEN_REG];
        d.imm     = insn[LEN_IMM-1:0];
        d.illegal = (d.opcode >= LEN_OPCODE'(NUM_OPCODES));
        return d;
    endfunction

endpackage

// File: rtl/insn_decoder_if.sv
// Handshake buses around the decoder.
//   insn_fetch_if  : fetch -> decoder, {insn, addr} beats, valid/stall.
//                    master = fetch unit, slave = decoder.
//   insn_decode_if : decoder -> execute, raw beat plus decoded fields, valid/stall.
//                    master = decoder, slave = execute stage.
interface insn_fetch_if;
    import insn_decoder_pkg::*;

    logic                     valid;
    logic                     stall;
    logic [LEN_INSN-1:0]      insn;
    logic [MEM_INSN_ADDR-1:0] addr;

    modport master (output valid, output insn, output addr, input stall);
    modport slave  (input valid, input insn, input addr, output stall);
endinterface

interface insn_decode_if;
    import insn_decoder_pkg::*;

    logic                     valid;
    logic                     stall;
    logic [LEN_INSN-1:0]      insn;
    logic [MEM_INSN_ADDR-1:0] addr;
    logic [LEN_OPCODE-1:0]    opcode;
    logic [LEN_REG-1:0]       rd;
    logic [LEN_REG-1:0]       rs;
    logic [LEN_IMM-1:0]       imm;
    logic                     illegal;

    modport master (output valid, output insn, output addr, output opcode, output rd,
                    output rs, output imm, output illegal, input stall);
    modport slave  (input valid, input insn, input addr, input opcode, input rd,
                    input rs, input imm, input illegal, output stall);
endinterface

// File: rtl/insn_skid_buffer.sv
// Two-entry skid buffer with registered stall and registered output beat.
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   flush_i             synchronous discard of everything held
//   in_valid/in_stall   upstream handshake (in_stall is a register)
//   in_data             upstream payload, sampled only on accept
//   out_valid/out_stall downstream handshake
//   out_data            payload of the presented (main) entry
//
// state      | meaning
// -----------+--------------------------------------------------
// SKID_EMPTY | nothing held, out_valid=0, in_stall=0
// SKID_ONE   | main entry holds the presented beat
// SKID_FULL  | main presented, skid holds overflow, in_stall=1
module insn_skid_buffer
    import insn_decoder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             in_valid,
    output logic             in_stall,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_stall,
    output logic [WIDTH-1:0] out_data
);

    skid_state_e      state;
    logic [WIDTH-1:0] skid_q;
    logic             accept;
    logic             consume;

    assign accept  = in_valid & ~in_stall;
    assign consume = out_valid & ~out_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= SKID_EMPTY;
            out_valid <= 1'b0;
            in_stall  <= 1'b0;
            out_data  <= '0;
            skid_q    <= '0;
        end else if (flush_i) begin
            // Flush wins over any accept/consume on the same edge.
            state     <= SKID_EMPTY;
            out_valid <= 1'b0;
            in_stall  <= 1'b0;
        end else begin
            case (state)
                SKID_EMPTY: begin
                    if (accept) begin
                        out_data  <= in_data;
                        out_valid <= 1'b1;
                        state     <= SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (accept && consume) begin
                        out_data <= in_data;
                    end else if (consume) begin
                        out_valid <= 1'b0;
                        state     <= SKID_EMPTY;
                    end else if (accept) begin
                        skid_q   <= in_data;
                        in_stall <= 1'b1;
                        state    <= SKID_FULL;
                    end
                end
                SKID_FULL: begin
                    // in_stall is high here, so accept cannot occur.
                    if (consume) begin
                        out_data <= skid_q;
                        in_stall <= 1'b0;
                        state    <= SKID_ONE;
                    end
                end
                default: begin
                    state     <= SKID_EMPTY;
                    out_valid <= 1'b0;
                    in_stall  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/insn_decoder.sv
// Consumer end of the instruction fetch bus. Buffers beats in a 2-entry skid
// buffer so the upstream stall is registered, and presents each beat to the
// execute stage together with its decoded fields.
// Ports:
//   clk      clock
//   rst      asynchronous active-low reset
//   flush_i  synchronous discard of all buffered beats
//   fetch    insn_fetch_if.slave  : valid/stall/insn/addr from fetch
//   dec      insn_decode_if.master: valid/stall, raw beat, opcode/rd/rs/imm/illegal
module insn_decoder
    import insn_decoder_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    insn_fetch_if.slave   fetch,
    insn_decode_if.master dec
);

    localparam int PAYLOAD_W = DEC_W + LEN_INSN + MEM_INSN_ADDR;

    dec_fields_t              fields_in;
    dec_fields_t              fields_out;
    logic [PAYLOAD_W-1:0]     pl_in;
    logic [PAYLOAD_W-1:0]     pl_out;
    logic                     stall_q;
    logic                     valid_q;
    logic [LEN_INSN-1:0]      insn_q;
    logic [MEM_INSN_ADDR-1:0] addr_q;

    // Decode at the input so the fields are stored with the beat rather than
    // recomputed from the held instruction on the output side.
    assign fields_in = decode_insn(fetch.insn);
    assign pl_in     = {fields_in, fetch.insn, fetch.addr};

    insn_skid_buffer #(
        .WIDTH (PAYLOAD_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (flush_i),
        .in_valid  (fetch.valid),
        .in_stall  (stall_q),
        .in_data   (pl_in),
        .out_valid (valid_q),
        .out_stall (dec.stall),
        .out_data  (pl_out)
    );

    assign {fields_out, insn_q, addr_q} = pl_out;

    assign fetch.stall = stall_q;
    assign dec.valid   = valid_q;
    assign dec.insn    = insn_q;
    assign dec.addr    = addr_q;
    assign dec.opcode  = fields_out.opcode;
    assign dec.rd      = fields_out.rd;
    assign dec.rs      = fields_out.rs;
    assign dec.imm     = fields_out.imm;
    assign dec.illegal = fields_out.illegal;

endmodule

// File: tb/tb_insn_decoder.sv
module tb_insn_decoder;

    logic clk;
    logic rst;
    logic flush;

    insn_fetch_if  fetch_bus ();
    insn_decode_if dec_bus ();

    insn_decoder dut (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .fetch   (fetch_bus),
        .dec     (dec_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    // Reference model: the ordered list of beats accepted and not yet consumed.
    // Each entry is {insn, addr}. Count 0/1/2 gives valid_o and stall_o.
    logic [41:0] mdl_q[$];
    logic        m_acc;
    int          n_con;

    // Upstream source state: a beat once offered is held until accepted.
    logic        pend;
    logic [31:0] p_insn;
    logic [9:0]  p_addr;
    logic [9:0]  next_addr;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs (at negedge), check outputs against the model,
    // advance the model over the posedge, return at the next negedge.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [9:0] ad,
                         input logic s, input logic f);
        logic        exp_v;
        logic        exp_s;
        logic        con;
        logic [31:0] h_insn;
        logic [31:0] op;
        fetch_bus.valid = v;
        fetch_bus.insn  = ins;
        fetch_bus.addr  = ad;
        dec_bus.stall   = s;
        flush           = f;
        exp_v = (mdl_q.size() > 0);
        exp_s = (mdl_q.size() == 2);
        chk_eq("valid_o", dec_bus.valid, exp_v);
        chk_eq("stall_o", fetch_bus.stall, exp_s);
        if (exp_v) begin
            h_insn = mdl_q[0][41:10];
            op     = h_insn >> 26;
            chk_eq("addr_o", dec_bus.addr, mdl_q[0][9:0]);
            chk_eq("insn_o", dec_bus.insn, h_insn);
            chk_eq("opcode_o", dec_bus.opcode, op);
            chk_eq("rd_o", dec_bus.rd, (h_insn >> 21) & 32'h1F);
            chk_eq("rs_o", dec_bus.rs, (h_insn >> 16) & 32'h1F);
            chk_eq("imm_o", dec_bus.imm, h_insn & 32'hFFFF);
            chk_eq("illegal_o", dec_bus.illegal, (op >= 40) ? 1 : 0);
        end
        m_acc = v && !exp_s;
        con   = exp_v && !s;
        @(posedge clk);
        if (f) begin
            mdl_q.delete();
            m_acc = 1'b0;
        end else begin
            if (con) begin
                void'(mdl_q.pop_front());
                n_con++;
            end
            if (m_acc) mdl_q.push_back({ins, ad});
        end
        @(negedge clk);
    endtask

    task automatic src_cycle(input logic want, input logic s, input logic f);
        if (!pend && want) begin
            pend      = 1'b1;
            p_addr    = next_addr;
            p_insn    = $urandom;
            next_addr = next_addr + 10'd1;
        end
        cycle(pend, p_insn, p_addr, s, f);
        if (m_acc || f) pend = 1'b0;
    endtask

    initial begin
        logic [31:0] ins;
        logic [9:0]  y_addr;
        logic [9:0]  held;
        int          base;
        int          cyc;

        n_cmp = 0;
        n_err = 0;
        n_con = 0;
        pend = 1'b0;
        p_insn = '0;
        p_addr = '0;
        next_addr = '0;
        rst = 1'b0;
        flush = 1'b0;
        fetch_bus.valid = 1'b0;
        fetch_bus.insn = '0;
        fetch_bus.addr = '0;
        dec_bus.stall = 1'b0;

        // Reset state
        #1;
        chk_eq("rst_valid_o", dec_bus.valid, 0);
        chk_eq("rst_stall_o", fetch_bus.stall, 0);
        chk_eq("rst_insn_o", dec_bus.insn, 0);
        chk_eq("rst_addr_o", dec_bus.addr, 0);
        chk_eq("rst_opcode_o", dec_bus.opcode, 0);
        chk_eq("rst_imm_o", dec_bus.imm, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Streaming: addr 0..7, no backpressure
        for (int i = 0; i < 8; i++) src_cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) src_cycle(1'b0, 1'b0, 1'b0);
        chk_eq("stream_count", n_con, 8);

        // Backpressure: stall_i from cycle 2, continuous input
        next_addr = 10'd16;
        for (int i = 0; i < 8; i++) begin
            src_cycle(1'b1, (i >= 2), 1'b0);
            if (i == 2) held = dec_bus.addr;
        end
        chk_eq("bp_stall_o", fetch_bus.stall, 1);
        chk_eq("bp_held_addr", dec_bus.addr, held);
        base = n_con;
        for (int i = 0; i < 8 && (pend || mdl_q.size() > 0); i++) src_cycle(1'b0, 1'b0, 1'b0);
        src_cycle(1'b0, 1'b0, 1'b0);
        chk_eq("bp_delivered", n_con - base, 3);

        // Directed decode
        cycle(1'b1, 32'h0C43_1234, 10'h100, 1'b0, 1'b0);
        chk_eq("dec_opcode", dec_bus.opcode, 3);
        chk_eq("dec_rd", dec_bus.rd, 2);
        chk_eq("dec_rs", dec_bus.rs, 3);
        chk_eq("dec_imm", dec_bus.imm, 16'h1234);
        chk_eq("dec_illegal0", dec_bus.illegal, 0);
        ins = {6'd45, 26'h2AB_CDEF};
        cycle(1'b1, ins, 10'h101, 1'b0, 1'b0);
        chk_eq("dec_illegal1", dec_bus.illegal, 1);
        chk_eq("dec_opcode45", dec_bus.opcode, 45);
        ins = {6'd39, 26'h0};
        cycle(1'b1, ins, 10'h102, 1'b0, 1'b0);
        chk_eq("dec_illegal39", dec_bus.illegal, 0);
        cycle(1'b0, 32'h0, 10'h0, 1'b0, 1'b0);

        // Flush in FULL with valid_i on the same edge
        for (int i = 0; i < 3; i++) src_cycle(1'b1, 1'b1, 1'b0);
        chk_eq("pre_flush_stall", fetch_bus.stall, 1);
        src_cycle(1'b1, 1'b1, 1'b1);
        chk_eq("flush_valid_o", dec_bus.valid, 0);
        chk_eq("flush_stall_o", fetch_bus.stall, 0);
        y_addr = next_addr;
        src_cycle(1'b1, 1'b0, 1'b0);
        chk_eq("flush_next_addr", dec_bus.addr, y_addr);
        src_cycle(1'b0, 1'b0, 1'b0);

        // Asynchronous reset while FULL
        for (int i = 0; i < 3; i++) src_cycle(1'b1, 1'b1, 1'b0);
        chk_eq("pre_rst_stall", fetch_bus.stall, 1);
        #2 rst = 1'b0;
        #1;
        chk_eq("arst_valid_o", dec_bus.valid, 0);
        chk_eq("arst_stall_o", fetch_bus.stall, 0);
        chk_eq("arst_addr_o", dec_bus.addr, 0);
        mdl_q.delete();
        pend = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        y_addr = next_addr;
        src_cycle(1'b1, 1'b0, 1'b0);
        chk_eq("rst_lat1_valid", dec_bus.valid, 1);
        chk_eq("rst_lat1_addr", dec_bus.addr, y_addr);
        src_cycle(1'b0, 1'b0, 1'b0);

        // Random traffic against the queue model
        base = n_con;
        cyc = 0;
        while ((n_con - base) < 10000 && cyc < 60000) begin
            src_cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b0);
            cyc++;
        end
        chk_eq("rand_delivered", n_con - base, 10000);
        for (int i = 0; i < 8 && (pend || mdl_q.size() > 0); i++) src_cycle(1'b0, 1'b0, 1'b0);
        src_cycle(1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
